uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART TX core among NUM_REQ byte requesters, one frame at a time.
// Define UART_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module uart_tx_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int GUARD_BITS = 1
) (
   input  logic                 clk_50M,
   input  logic                 reset_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 write,
   output logic [7:0]           write_value,
   output logic [2:0]           grant_id,
   output logic                 busy
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int FRAME_CYCLES = CLKS_PER_BIT * (10 + GUARD_BITS);
   localparam int CNT_W        = $clog2(FRAME_CYCLES);
   localparam int PTR_W        = $clog2(NUM_REQ);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   win;
   logic [7:0]         win_byte;
   logic               grant;
   logic               cnt_done;
   logic [NUM_REQ-1:0] ack_d;
   logic               write_d;
   logic               busy_d;
   logic [7:0]         wv_d;
   logic [2:0]         gid_d;

`ifdef UART_ARB_FIXED_PRIO_EN
   always_comb begin
      win = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req[PTR_W'(i)]) win = PTR_W'(i);
   end
`else
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W:0]   rr_sum;
   logic             found;

   // Search starts one past the last winner and wraps modulo NUM_REQ.
   always_comb begin
      win    = '0;
      found  = 1'b0;
      rr_sum = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         rr_sum = {1'b0, rr_ptr} + (PTR_W+1)'(i);
         if (rr_sum >= (PTR_W+1)'(NUM_REQ)) rr_sum = rr_sum - (PTR_W+1)'(NUM_REQ);
         if (!found && req[rr_sum[PTR_W-1:0]]) begin
            win   = rr_sum[PTR_W-1:0];
            found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n)   rr_ptr <= PTR_W'(NUM_REQ - 1);
      else if (grant) rr_ptr <= win;
   end
`endif

   always_comb begin
      win_byte = 8'h00;
      for (int i = 0; i < NUM_REQ; i++)
         if (win == PTR_W'(i)) win_byte = req_data[8*i +: 8];
   end

   assign grant    = (state_q == S_IDLE) && (|req);
   assign cnt_done = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (|req)    state_d = S_WAIT;
         S_WAIT:  if (cnt_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // cnt parks at its last value in IDLE rather than wrapping; a grant clears it.
   always_comb begin
      write_d = grant;
      ack_d   = '0;
      busy_d  = busy;
      wv_d    = write_value;
      gid_d   = grant_id;
      cnt_d   = cnt_q;
      if (grant) begin
         ack_d  = NUM_REQ'(1) << win;
         busy_d = 1'b1;
         wv_d   = win_byte;
         gid_d  = 3'(win);
         cnt_d  = '0;
      end else if (state_q == S_WAIT) begin
         if (cnt_done) busy_d = 1'b0;
         else          cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_50M or negedge reset_n) begin
      if (!reset_n) begin
         write       <= 1'b0;
         ack         <= '0;
         busy        <= 1'b0;
         write_value <= 8'h00;
         grant_id    <= 3'd0;
         cnt_q       <= '0;
      end else begin
         write       <= write_d;
         ack         <= ack_d;
         busy        <= busy_d;
         write_value <= wv_d;
         grant_id    <= gid_d;
         cnt_q       <= cnt_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, corner-case sequences and
// randomized traffic against a cycle-count reference model plus a byte decoder.
module tb_uart_tx_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int CLK_FREQ   = 1000;
   localparam int BAUD       = 100;
   localparam int GUARD_BITS = 1;
   localparam int CPB        = CLK_FREQ / BAUD;
   localparam int FC         = CPB * (10 + GUARD_BITS);

   logic                 clk_50M = 1'b0;
   logic                 reset_n;
   logic [NUM_REQ-1:0]   req;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   ack;
   logic                 write;
   logic [7:0]           write_value;
   logic [2:0]           grant_id;
   logic                 busy;

   uart_tx_arbiter #(
      .NUM_REQ(NUM_REQ), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .GUARD_BITS(GUARD_BITS)
   ) dut (
      .clk_50M(clk_50M), .reset_n(reset_n), .req(req), .req_data(req_data),
      .ack(ack), .write(write), .write_value(write_value), .grant_id(grant_id), .busy(busy)
   );

   always #5 clk_50M = ~clk_50M;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model state: outputs expected after the current edge.
   logic [NUM_REQ-1:0] m_ack   = '0;
   logic               m_write = 1'b0;
   logic               m_busy  = 1'b0;
   logic [7:0]         m_wv    = 8'h00;
   logic [2:0]         m_gid   = 3'd0;
   int                 m_ptr   = NUM_REQ - 1;
   int                 m_gedge = 0;
   logic [7:0]         exp_q[$];
   logic [7:0]         dec_q[$];

   function automatic int pick(input logic [NUM_REQ-1:0] r, input int ptr);
      int w = -1;
      int idx;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = i;
         if (r[idx[1:0]]) w = idx;
      end
`else
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = (ptr + off) % NUM_REQ;
         if (r[idx[1:0]]) w = idx;
      end
`endif
      return w;
   endfunction

   function automatic void model_reset();
      if (m_busy === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_back());
      m_ack   = '0;
      m_write = 1'b0;
      m_busy  = 1'b0;
      m_wv    = 8'h00;
      m_gid   = 3'd0;
      m_ptr   = NUM_REQ - 1;
   endfunction

   function automatic void model_edge();
      int w;
      if (!reset_n) begin
         model_reset();
      end else begin
         m_write = 1'b0;
         m_ack   = '0;
         if (m_busy) begin
            if (cyc - m_gedge == FC) m_busy = 1'b0;
         end else if (req != '0) begin
            w       = pick(req, m_ptr);
            m_write = 1'b1;
            m_ack   = NUM_REQ'(1) << w;
            m_wv    = req_data[8*w +: 8];
            m_gid   = 3'(w);
            m_busy  = 1'b1;
            m_ptr   = w;
            m_gedge = cyc;
            exp_q.push_back(m_wv);
         end
      end
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk_50M);
      cyc++;
      model_edge();
      #1;
      n_checks++;
      if ({ack, write, write_value, grant_id, busy} !== {m_ack, m_write, m_wv, m_gid, m_busy}) begin
         n_errors++;
         $display("FAIL cycle %0d: ack=%b write=%b wv=%h gid=%0d busy=%b, expected ack=%b write=%b wv=%h gid=%0d busy=%b",
                  cyc, ack, write, write_value, grant_id, busy, m_ack, m_write, m_wv, m_gid, m_busy);
      end
   endtask

   task automatic do_reset(input int hold);
      #2 reset_n = 1'b0;
      #1 chk("rst_async", {ack, write, write_value, grant_id, busy}, 32'h0);
      model_reset();
      repeat (hold) step();
      reset_n = 1'b1;
   endtask

   task automatic wait_ack(input int budget, output int id, output int at);
      bit done;
      done = 1'b0;
      id   = -1;
      at   = -1;
      for (int c = 0; c < budget && !done; c++) begin
         step();
         if (|ack) begin
            for (int i = 0; i < NUM_REQ; i++) if (ack[i]) id = i;
            at   = cyc;
            req  = req & ~ack;
            done = 1'b1;
         end
      end
      n_checks++;
      if (!done) begin
         n_errors++;
         $display("FAIL ack_timeout: no ack within %0d cycles, expected one", budget);
      end
   endtask

   // Byte decoder: samples write_value at each data-bit centre of the frame.
   initial begin : decoder
      logic [7:0] b;
      bit         abort;
      forever begin
         @(posedge clk_50M);
         #1;
         if (write === 1'b1) begin
            abort = 1'b0;
            b     = 8'h00;
            for (int k = 0; k < 8 && !abort; k++) begin
               for (int c = 0; c < ((k == 0) ? CPB + CPB / 2 : CPB) && !abort; c++) begin
                  @(negedge clk_50M);
                  if (!reset_n) abort = 1'b1;
               end
               if (!abort) b[k] = write_value[k];
            end
            if (!abort) dec_q.push_back(b);
         end
      end
   end

   typedef struct {
      logic [NUM_REQ-1:0]   req;
      logic [8*NUM_REQ-1:0] data;
      logic                 wr;
      logic [NUM_REQ-1:0]   ack;
      logic [2:0]           gid;
      logic [7:0]           wv;
      logic                 busy;
   } vec_t;

   initial begin : main
      vec_t vt[6];
      int   id, at, prev, n_ack, nd;

      vt[0] = '{req:4'b0001, data:32'h78563412, wr:1'b1, ack:4'b0001, gid:3'd0, wv:8'h12, busy:1'b1};
      vt[1] = '{req:4'b1111, data:32'hA1B2C3D4, wr:1'b1, ack:4'b0001, gid:3'd0, wv:8'hD4, busy:1'b1};
      vt[2] = '{req:4'b1010, data:32'hA1B2C3D4, wr:1'b1, ack:4'b0010, gid:3'd1, wv:8'hC3, busy:1'b1};
      vt[3] = '{req:4'b1000, data:32'h5A000000, wr:1'b1, ack:4'b1000, gid:3'd3, wv:8'h5A, busy:1'b1};
      vt[4] = '{req:4'b0100, data:32'h00EE0000, wr:1'b1, ack:4'b0100, gid:3'd2, wv:8'hEE, busy:1'b1};
      vt[5] = '{req:4'b0000, data:32'hFFFFFFFF, wr:1'b0, ack:4'b0000, gid:3'd0, wv:8'h00, busy:1'b0};

      reset_n  = 1'b0;
      req      = '0;
      req_data = '0;
      model_reset();
      repeat (3) step();
      reset_n = 1'b1;
      chk("reset_state", {ack, write, write_value, grant_id, busy}, 32'h0);

      // First grant after reset: lowest set index wins, outputs one cycle later.
      foreach (vt[v]) begin
         do_reset(2);
         req      = vt[v].req;
         req_data = vt[v].data;
         step();
         chk($sformatf("vec%0d", v), {write, ack, grant_id, write_value, busy},
             {vt[v].wr, vt[v].ack, vt[v].gid, vt[v].wv, vt[v].busy});
         req = '0;
      end

      // All four at once: order 0,1,2,3, writes exactly FC+1 apart.
      do_reset(2);
      req      = 4'b1111;
      req_data = 32'h78563412;
      prev     = 0;
      for (int k = 0; k < 4; k++) begin
         wait_ack(FC + 10, id, at);
         chk("t2_order", id, k);
         if (k > 0) chk("t2_spacing", at - prev, FC + 1);
         prev = at;
      end

      // Wrap: after granting 2, request 0 and 2 -> 0 first, then 2.
      do_reset(2);
      req      = 4'b0100;
      req_data = 32'h00CC00AA;
      wait_ack(FC + 10, id, at);
      chk("t3_first", id, 2);
      req  = 4'b0101;
      prev = at;
      wait_ack(FC + 10, id, at);
      chk("t3_wrap", id, 0);
      chk("t3_spacing", at - prev, FC + 1);
      wait_ack(FC + 10, id, at);
      chk("t3_next", id, 2);

      // Request raised during WAIT waits for IDLE, granted at E+FC+1.
      do_reset(2);
      req      = 4'b0001;
      req_data = 32'h00009901;
      wait_ack(FC + 10, id, prev);
      repeat (5) step();
      req = 4'b0010;
      wait_ack(FC + 10, id, at);
      chk("t4_id", id, 1);
      chk("t4_delay", at - prev, FC + 1);

      // Reset mid-frame abandons the byte; pointer restarts so req[0] wins again.
      do_reset(2);
      req      = 4'b0011;
      req_data = 32'h0000B7A5;
      wait_ack(FC + 10, id, at);
      chk("t5_first", id, 0);
      repeat (50) step();
      do_reset(100);
      req = 4'b0011;
      wait_ack(FC + 10, id, at);
      chk("t5_after_reset", id, 0);
      wait_ack(FC + 10, id, at);
      chk("t5_second", id, 1);

      // One-cycle pulse during WAIT is never granted.
      repeat (FC + 5) step();
      req = 4'b0001;
      wait_ack(FC + 10, id, at);
      repeat (10) step();
      req      = 4'b0100;
      req_data = 32'h00770000;
      step();
      req   = '0;
      n_ack = 0;
      for (int c = 0; c < FC + 20; c++) begin
         step();
         if (|ack) n_ack++;
      end
      chk("t6_no_ack", n_ack, 0);

      // Randomized traffic: requesters hold until ack, occasionally give up early.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req[i] && $urandom_range(0, 7) == 0) begin
               req[i]             = 1'b1;
               req_data[8*i +: 8] = 8'($urandom);
            end else if (req[i] && $urandom_range(0, 299) == 0) begin
               req[i] = 1'b0;
            end
         end
         step();
         req = req & ~ack;
      end

      req = '0;
      repeat (FC + 20) step();
      chk("dec_count", dec_q.size(), exp_q.size());
      nd = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
      for (int i = 0; i < nd; i++) chk($sformatf("dec_byte%0d", i), dec_q[i], exp_q[i]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
